// File: rtl/shift_reg_pkg.sv
// Shared definitions for the 4-bit universal shift register and its command sequencer.
// Mode encodings match the register's 'mode' input; the state enum is owned by the sequencer.
package shift_reg_pkg;

    localparam logic [1:0] SR_HOLD  = 2'b00;
    localparam logic [1:0] SR_LEFT  = 2'b01;
    localparam logic [1:0] SR_RIGHT = 2'b10;
    localparam logic [1:0] SR_LOAD  = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_RESP  = 2'd3
    } sr_seq_state_e;

    function automatic logic [1:0] shift_mode(input logic dir);
        return (dir == DIR_RIGHT) ? SR_RIGHT : SR_LEFT;
    endfunction

endpackage

// File: rtl/lab2_shift_reg.sv
// 4-bit universal shift register: hold, left shift, right shift, parallel load.
// Deliberately has no reset; its contents are owned by whoever sequences it.
module lab2_shift_reg
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] p_in,
    input  logic             s_in,
    output logic [WIDTH-1:0] q_out,
    output logic             is_zero
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        unique case (mode)
            SR_LEFT:  r_q <= {r_q[WIDTH-2:0], s_in};
            SR_RIGHT: r_q <= {s_in, r_q[WIDTH-1:1]};
            SR_LOAD:  r_q <= p_in;
            default:  r_q <= r_q;
        endcase
    end

    assign q_out   = r_q;
    assign is_zero = (r_q == '0);

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command-driven controller for lab2_shift_reg: accepts load+shift commands over
// valid/ready, drives the register's mode/p_in/s_in, and returns the result over valid/ready.
module shift_reg_sequencer
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic             cmd_fill,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             busy,
    output logic [1:0]       sr_mode,
    output logic [WIDTH-1:0] sr_p_in,
    output logic             sr_s_in,
    input  logic [WIDTH-1:0] sr_q,
    input  logic             sr_zero
);

    localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

    sr_seq_state_e    r_state;
    sr_seq_state_e    w_state_nxt;

    logic             r_dir;
    logic [WIDTH-1:0] r_data;
    logic [AMT_W-1:0] r_amt;
    logic             r_fill;
    logic [AMT_W-1:0] r_cnt;

    logic             w_accept;

    assign w_accept = (r_state == ST_IDLE) && cmd_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command capture and shift down-counter; cnt only moves in SHIFT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dir  <= DIR_LEFT;
            r_data <= '0;
            r_amt  <= '0;
            r_fill <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_dir  <= cmd_dir;
            r_data <= cmd_data;
            r_amt  <= cmd_amt;
            r_fill <= cmd_fill;
            r_cnt  <= cmd_amt;
        end else if (r_state == ST_SHIFT) begin
            r_cnt  <= r_cnt - CNT_ONE;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_nxt = (r_amt == '0) ? ST_RESP : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_zero  = 1'b0;
        busy      = 1'b1;
        sr_mode   = SR_HOLD;
        unique case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_LOAD: begin
                sr_mode = SR_LOAD;
            end
            ST_SHIFT: begin
                sr_mode = shift_mode(r_dir);
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = sr_q;
                rsp_zero  = sr_zero;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign sr_p_in = r_data;
    assign sr_s_in = r_fill;

endmodule

// File: doc/shift_reg_sequencer.md
# shift_reg_sequencer

Command-driven controller for the 4-bit universal shift register (`lab2_shift_reg`: hold, left shift, right shift and parallel load). It accepts one command per transaction over a valid/ready handshake: load a word, shift it N places left or right with a chosen fill bit, then return the result and the zero flag over a valid/ready response channel. It owns the register's `mode`, `p_in` and `s_in` inputs and sits between a requester and the register.

## Interface
- `WIDTH`, 4: data width; must equal the shift register width.
- `AMT_W`, 3: width of the shift-amount field (0..2^AMT_W-1).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller can accept a command.
- `cmd_dir` in 1: 0 = shift left, 1 = shift right.
- `cmd_data` in WIDTH: word to parallel-load.
- `cmd_amt` in AMT_W: number of single-bit shifts after the load.
- `cmd_fill` in 1: serial bit shifted in on every shift.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: requester takes the result.
- `rsp_data` out WIDTH: register contents at completion.
- `rsp_zero` out 1: zero flag at completion.
- `busy` out 1: high in every state except IDLE.
- `sr_mode` out 2: to register `mode`. 00 hold, 01 left (fill into LSB), 10 right (fill into MSB), 11 load.
- `sr_p_in` out WIDTH: to register `p_in`.
- `sr_s_in` out 1: to register `s_in`.
- `sr_q` in WIDTH: from register `q_out`.
- `sr_zero` in 1: from register `is_zero`.

## Operation
- FSM states: IDLE, LOAD, SHIFT, RESP. All outputs are decoded from the state and the captured command registers.
- IDLE: `cmd_ready`=1, `sr_mode`=00. When `cmd_valid` is high at an edge, capture `dir`, `data`, `amt` and `fill`, set `cnt`=`amt`, and go to LOAD.
- LOAD: `sr_mode`=11 and `sr_p_in`=captured data. Go to RESP if `amt`==0, otherwise go to SHIFT.
- SHIFT: `sr_mode`=`dir`?10:01 and `sr_s_in`=captured fill. `cnt` decrements on every edge. Go to RESP on the edge where `cnt`==1.
- RESP: `sr_mode`=00. `rsp_valid`=1, `rsp_data`=`sr_q`, `rsp_zero`=`sr_zero`. Go to IDLE on the edge where `rsp_ready` is high.
- `cmd_valid` is ignored outside IDLE. There is no queueing.
- An `amt` of WIDTH or more is legal. The register then fully flushes, and the result is all fill bits.
- `sr_p_in` holds the captured data in every state; it has meaning only in LOAD. `sr_s_in` holds the captured fill bit.
- The shift register has no reset. The controller never clears it; `rsp_data` reflects only the sequenced command.

## Timing
- Accept edge E0. The register loads at E1. Shift k occurs at edge E(1+k).
- `rsp_valid` rises after edge E(1+amt). Latency is amt+1 cycles from accept to `rsp_valid`.
- Under backpressure, `rsp_valid`, `rsp_data` and `rsp_zero` are stable until the handshake, because the register is held in RESP.
- After the response handshake at edge Er, the next command can be accepted at Er+1 at the earliest. Minimum command period is amt+3 cycles.
- Reset values, effective after the first edge with `rst_n`=0:
  - state IDLE, `cnt`=0;
  - `cmd_ready`=1, `rsp_valid`=0, `busy`=0;
  - `sr_mode`=00, `sr_s_in`=0, `sr_p_in`=0.
- Reset mid-operation in any state: the command is abandoned, no response is issued, and the register holds its partial value.
- `rst_n` low overrides a simultaneous `cmd_valid` or `rsp_ready`.

## Structure
- Shared package `shift_reg_pkg` holds:
  - mode constants `SR_HOLD`=2'b00, `SR_LEFT`=2'b01, `SR_RIGHT`=2'b10, `SR_LOAD`=2'b11;
  - `DIR_LEFT`=0, `DIR_RIGHT`=1;
  - the FSM state enum `sr_seq_state_e`.
- No internal sub-module. The FSM plus down-counter is a single module.
- The integration level and the bench connect the `sr_*` ports to `lab2_shift_reg`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `cmd_valid`=1 -> `cmd_ready`=1, `rsp_valid`=0, `busy`=0, `sr_mode`=00, and no command accepted.
- Load only: data 0101, amt 0 -> `rsp_valid` 1 cycle after accept, `rsp_data`=0101, `rsp_zero`=0, `sr_mode` sequence 11,00.
- Left shift: data 0001, left, amt 2, fill 1 -> `sr_mode` sequence 11,01,01,00, `rsp_data`=0111 after 3 cycles.
- Right flush: data 0111, right, amt 5, fill 0 -> `rsp_data`=0000, `rsp_zero`=1, latency 6.
- Backpressure: `rsp_ready`=0 for 4 cycles with `cmd_valid`=1 -> `rsp_*` stable, `cmd_ready`=0, and the second command is accepted only 1 cycle after the response handshake.
- Reset mid-SHIFT: amt 7, `rst_n`=0 during the 3rd shift cycle -> IDLE on the next edge, `sr_mode`=00, no `rsp_valid`, and a new command then completes normally.
